// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic initiator.
//   WB_ADDR_W / WB_DATA_W / WB_SEL_W : bus widths
//   wb_init_state_t                  : initiator FSM encoding
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_init_state_t;

endpackage

// File: rtl/wb_init_timeout.sv
// Bus-cycle watchdog for wb_initiator (only instantiated when
// WB_INITIATOR_TIMEOUT_EN is defined).
//   i_clk, i_reset_n : clock, async active-low reset
//   i_clear          : request accepted; restart the count for the new cycle
//   i_active         : initiator is in BUS
//   i_ack            : Wishbone acknowledge
//   o_expire         : last allowed stb cycle passed without ack
module wb_init_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expire
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_active && !i_ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the expiry cycle takes priority over the abort.
    assign o_expire = i_active && !i_ack && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator for the CPU load/store/fetch
// port. One request at a time: accept -> bus cycle -> one-cycle response.
//
// Optional macro: WB_INITIATOR_TIMEOUT_EN -- abort a bus cycle that sees no
// ack for TIMEOUT_CYCLES stb cycles and respond with o_rsp_err = 1.
//
// Ports:
//   i_clk, i_reset_n           clock, async active-low reset
//   i_req_* / o_req_ready      core request (valid/ready)
//   o_rsp_valid/rdata/err      one-cycle response pulse, rdata held after
//   o_wb_* / i_wb_dat/ack      Wishbone classic initiator side
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request (ready is registered, so low right after reset)
// BUS   | cyc/stb high, o_wb_* held, waiting for ack (or timeout)
// RESP  | o_rsp_valid pulse, ready low
module wb_initiator
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_ALIGN     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [WB_ADDR_W-1:0] i_req_addr,
    input  logic [WB_DATA_W-1:0] i_req_wdata,
    input  logic [WB_SEL_W-1:0]  i_req_sel,
    output logic                 o_rsp_valid,
    output logic [WB_DATA_W-1:0] o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic [WB_ADDR_W-1:0] o_wb_adr,
    output logic [WB_DATA_W-1:0] o_wb_dat,
    output logic [WB_SEL_W-1:0]  o_wb_sel,
    output logic                 o_wb_we,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic [WB_DATA_W-1:0] i_wb_dat,
    input  logic                 i_wb_ack
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT_CYCLES must be in 2..255");
    end

    wb_init_state_t state_q, state_d;

    logic                 ready_q, ready_d;
    logic                 cyc_q, cyc_d;
    logic [WB_ADDR_W-1:0] adr_q, adr_d;
    logic [WB_DATA_W-1:0] dat_q, dat_d;
    logic [WB_SEL_W-1:0]  sel_q, sel_d;
    logic                 we_q, we_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [WB_DATA_W-1:0] rdata_q, rdata_d;

    logic accept;
    logic timeout_expire;

    assign accept = (state_q == IDLE) && ready_q && i_req_valid;

`ifdef WB_INITIATOR_TIMEOUT_EN
    wb_init_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_clear  (accept),
        .i_active (state_q == BUS),
        .i_ack    (i_wb_ack),
        .o_expire (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (i_wb_ack || timeout_expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; every output is registered so the bus
    // sees glitch-free cyc/stb and reset clears them asynchronously.
    always_comb begin
        ready_d     = (state_d == IDLE);
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    adr_d = (ADDR_ALIGN != 0) ? {i_req_addr[WB_ADDR_W-1:2], 2'b00}
                                              : i_req_addr;
                    dat_d = i_req_wdata;
                    sel_d = i_req_sel;
                    we_d  = i_req_we;
                    cyc_d = 1'b1;
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!we_q) rdata_d = i_wb_dat;
                end else if (timeout_expire) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_we     = we_q;
    // cyc and stb share one flop so they can never diverge.
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_sel = '0;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;

    logic        a0_req_ready, a0_rsp_valid, a0_rsp_err;
    logic [31:0] a0_rsp_rdata, a0_wb_adr, a0_wb_dat;
    logic [3:0]  a0_wb_sel;
    logic        a0_wb_we, a0_wb_cyc, a0_wb_stb;

    logic [31:0] wb_rdat = '0;
    logic        wb_ack;
    logic        rack = 1'b0;
    logic        force_ack = 1'b0;
    logic        resp_en = 1'b1;
    int          delay = 1;
    int          wcnt = 0;
    logic [31:0] mem [16] = '{default: 32'h0};

    always #5 clk = ~clk;

    assign wb_ack = rack | force_ack;

    wb_initiator #(.TIMEOUT_CYCLES(16), .ADDR_ALIGN(1)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_sel(req_sel),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack)
    );

    wb_initiator #(.TIMEOUT_CYCLES(16), .ADDR_ALIGN(0)) u_dut_a0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(a0_req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_sel(req_sel),
        .o_rsp_valid(a0_rsp_valid), .o_rsp_rdata(a0_rsp_rdata), .o_rsp_err(a0_rsp_err),
        .o_wb_adr(a0_wb_adr), .o_wb_dat(a0_wb_dat), .o_wb_sel(a0_wb_sel), .o_wb_we(a0_wb_we),
        .o_wb_cyc(a0_wb_cyc), .o_wb_stb(a0_wb_stb), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack)
    );

    // RAM responder: acks 'delay' cycles after first seeing stb.
    always @(posedge clk) begin
        rack <= 1'b0;
        if (wb_cyc && wb_stb && resp_en && !rack) begin
            if (wcnt >= delay - 1) begin
                rack <= 1'b1;
                wcnt <= 0;
                if (wb_we) begin
                    for (int b = 0; b < 4; b++)
                        if (wb_sel[b]) mem[wb_adr[5:2]][8*b +: 8] <= wb_dat[8*b +: 8];
                end else begin
                    wb_rdat <= mem[wb_adr[5:2]];
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else if (!wb_cyc) begin
            wcnt <= 0;
        end
    end

    int   errs = 0;
    int   checks = 0;
    int   cyc_after_ack = 0;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (prev_ack && wb_cyc) cyc_after_ack++;
        prev_ack = wb_ack;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          dly;
        logic        en;
        logic [31:0] exp_adr;
        logic [31:0] exp_adr0;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_stb;
    } vec_t;

    // Starts at a negedge where ready is expected high (cycle T0) and returns
    // at the negedge where ready has come back.
    task automatic run_vec(input string nm, input vec_t v);
        int lat = -1, ready_t = -1, stbc = 0, pulses = 0;
        logic stable = 1'b1, ready_ok = 1'b1, have = 1'b0, err_seen = 1'b0;
        logic [31:0] rdata_seen = '0, adr_f = '0, adr0_f = '0, dat_f = '0;
        logic [3:0] sel_f = '0;
        logic we_f = 1'b0;
        chk({nm, " ready_at_T0"}, 32'(req_ready), 32'h1);
        resp_en = v.en; delay = v.dly;
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_sel = v.sel;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 1; t < 60 && ready_t < 0; t++) begin
            if (wb_cyc) begin
                if (!wb_stb) stable = 1'b0;
                if (!have) begin
                    adr_f = wb_adr; adr0_f = a0_wb_adr; dat_f = wb_dat; sel_f = wb_sel; we_f = wb_we;
                    have = 1'b1;
                end else if (wb_adr !== adr_f || wb_dat !== dat_f || wb_sel !== sel_f || wb_we !== we_f) begin
                    stable = 1'b0;
                end
                stbc++;
            end
            if (rsp_valid) begin
                pulses++;
                if (lat < 0) begin lat = t; err_seen = rsp_err; rdata_seen = rsp_rdata; end
            end
            if (req_ready) begin
                if (lat > 0 && t > lat) ready_t = t;
                else ready_ok = 1'b0;
            end
            if (ready_t < 0) @(negedge clk);
        end
        chk({nm, " wb_adr"}, adr_f, v.exp_adr);
        chk({nm, " wb_adr_noalign"}, adr0_f, v.exp_adr0);
        chk({nm, " wb_dat/sel/we"}, {dat_f[27:0], sel_f}, {v.wdata[27:0], v.sel});
        chk({nm, " wb_we"}, 32'(we_f), 32'(v.we));
        chk({nm, " wb_stable"}, 32'(stable), 32'h1);
        chk({nm, " stb_cycles"}, 32'(stbc), 32'(v.exp_stb));
        chk({nm, " rsp_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, " rsp_pulses"}, 32'(pulses), 32'h1);
        chk({nm, " rsp_err"}, 32'(err_seen), 32'(v.exp_err));
        chk({nm, " rsp_rdata"}, rdata_seen, v.exp_rdata);
        chk({nm, " ready_low"}, 32'(ready_ok), 32'h1);
        chk({nm, " ready_return"}, 32'(ready_t), 32'(v.exp_lat + 1));
        resp_en = 1'b1; delay = 1;
    endtask

    vec_t tbl [6];
    vec_t vx;

    initial begin
        int acc [3];
        int nacc;
        int pulses;
        int cyc_cnt;

        tbl[0] = '{1'b1, 32'h0000_0008, 32'h0000_00A5, 4'b0001, 1, 1'b1,
                   32'h0000_0008, 32'h0000_0008, 32'h0000_0000, 1'b0, 3, 2};
        tbl[1] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'b1111, 1, 1'b1,
                   32'h0000_0008, 32'h0000_0008, 32'h0000_00A5, 1'b0, 3, 2};
        tbl[2] = '{1'b1, 32'h0000_0013, 32'h1122_3344, 4'b1111, 1, 1'b1,
                   32'h0000_0010, 32'h0000_0013, 32'h0000_00A5, 1'b0, 3, 2};
        tbl[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 5, 1'b1,
                   32'h0000_0010, 32'h0000_0010, 32'h1122_3344, 1'b0, 7, 6};
        tbl[4] = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0011, 2, 1'b1,
                   32'h0000_0020, 32'h0000_0020, 32'h1122_3344, 1'b0, 4, 3};
        tbl[5] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 1, 1'b1,
                   32'h0000_0020, 32'h0000_0020, 32'h0000_BEEF, 1'b0, 3, 2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ctrl", {23'h0, req_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we, wb_sel}, 32'h0);
        chk("reset wb_adr", wb_adr, 32'h0);
        chk("reset wb_dat", wb_dat, 32'h0);
        chk("reset rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        #1 chk("ready before first edge", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("ready after first edge", 32'(req_ready), 32'h1);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Back-to-back reads with valid held
        nacc = 0; pulses = 0;
        req_we = 1'b0; req_addr = 32'h8; req_sel = 4'hF; req_valid = 1'b1;
        for (int t = 0; t < 15; t++) begin
            if (nacc == 3) req_valid = 1'b0;
            if (req_valid && req_ready) begin acc[nacc] = t; nacc++; end
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b accepts", 32'(nacc), 32'd3);
        chk("b2b accept T4", 32'(acc[1] - acc[0]), 32'd4);
        chk("b2b accept T8", 32'(acc[2] - acc[0]), 32'd8);
        chk("b2b pulses", 32'(pulses), 32'd3);
        chk("b2b rdata", rsp_rdata, 32'h0000_00A5);

        // Spurious ack while idle
        pulses = 0; cyc_cnt = 0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        for (int t = 0; t < 3; t++) begin
            if (rsp_valid) pulses++;
            if (wb_cyc || !req_ready) cyc_cnt++;
            @(negedge clk);
        end
        chk("spurious ack rsp", 32'(pulses), 32'd0);
        chk("spurious ack idle", 32'(cyc_cnt), 32'd0);

`ifdef WB_INITIATOR_TIMEOUT_EN
        vx = '{1'b0, 32'h0000_0004, 32'h0, 4'hF, 1, 1'b0,
               32'h0000_0004, 32'h0000_0004, 32'h0000_00A5, 1'b1, 17, 16};
        run_vec("timeout", vx);
        vx = '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 15, 1'b1,
               32'h0000_0020, 32'h0000_0020, 32'h0000_BEEF, 1'b0, 17, 16};
        run_vec("ack_on_expiry", vx);
`endif

        // Stalled cycle, then reset in the middle of BUS
        resp_en = 1'b0;
        req_we = 1'b0; req_addr = 32'h8; req_sel = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0; cyc_cnt = 0;
`ifdef WB_INITIATOR_TIMEOUT_EN
        repeat (2) begin
            if (wb_cyc) cyc_cnt++;
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        chk("stall cyc cycles", 32'(cyc_cnt), 32'd2);
`else
        repeat (30) begin
            if (wb_cyc) cyc_cnt++;
            if (rsp_valid || rsp_err) pulses++;
            @(negedge clk);
        end
        chk("hung cyc cycles", 32'(cyc_cnt), 32'd30);
`endif
        chk("stall no rsp", 32'(pulses), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("async reset bus", {28'h0, wb_cyc, wb_stb, rsp_valid, req_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        chk("post reset ready", 32'(req_ready), 32'h1);
        vx = '{1'b0, 32'h0000_0008, 32'h0, 4'hF, 1, 1'b1,
               32'h0000_0008, 32'h0000_0008, 32'h0000_00A5, 1'b0, 3, 2};
        run_vec("post_reset_read", vx);

        chk("cyc after ack", 32'(cyc_after_ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
